// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem fetch and a
// registered valid/ready slot toward decode, flushed by execute redirects.
module fetch_unit #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } slot_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic            discard;
    slot_t           slot;

    logic            xfer;
    logic            slot_free;
    logic            fire;
    logic [XLEN-1:0] redirect_pc;

    assign xfer        = slot.valid && instr_ready;
    assign slot_free   = !slot.valid || instr_ready;
    assign redirect_pc = {redirect_target[XLEN-1:2], 2'b00};

    // Request is suppressed on redirect so the stale fetch_pc can never be granted.
    assign imem_req  = !rst && !redirect && (state == S_REQ) && slot_free;
    assign imem_addr = rst ? RESET_PC : fetch_pc;
    assign fire      = imem_req && imem_gnt;

    assign instr_valid    = slot.valid;
    assign instr          = slot.instr;
    assign instr_pc       = slot.pc;
    assign instr_pc_plus4 = slot.pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            discard    <= 1'b0;
            slot.valid <= 1'b0;
            slot.instr <= NOP_INSTR;
            slot.pc    <= '0;
        end else if (redirect) begin
            fetch_pc   <= redirect_pc;
            slot.valid <= 1'b0;
            slot.instr <= NOP_INSTR;
            // A response still in flight belongs to the wrong path.
            if (state == S_WAIT) begin
                if (imem_rvalid) begin
                    discard <= 1'b0;
                    state   <= S_REQ;
                end else begin
                    discard <= 1'b1;
                end
            end
        end else begin
            if (xfer)
                slot.valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (fire)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                        if (discard) begin
                            discard <= 1'b0;
                        end else begin
                            slot     <= '{valid: 1'b1, instr: imem_rdata, pc: fetch_pc};
                            fetch_pc <= fetch_pc + XLEN'(4);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with variable gnt/rvalid delay and a
// program-order PC model checked on every decode transfer and every grant.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference: the PC decode must receive next, in program order.
    logic [31:0] exp_pc = '0;

    // Memory model
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          gwait = 0;
    int          gnt_cfg = 0;
    int          lat_cfg = 1;

    logic [31:0] gnt_log[$];
    logic [31:0] xfer_log[$];
    int          xfer_cyc[$];

    bit          p_stall = 1'b0, p_pend = 1'b0, p_redir = 1'b0;
    logic [31:0] p_instr = '0, p_pc = '0, p_addr = '0;
    bit          last_req = 1'b0, last_gnt = 1'b0, last_rvalid = 1'b0;
    logic [31:0] last_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    function automatic int pick(input int cfg, input int lo, input int hi);
        if (cfg < 0) return int'($urandom_range(hi, lo));
        return cfg;
    endfunction

    task automatic set_mem(input int g, input int l);
        gnt_cfg = g;
        lat_cfg = l;
        gwait   = pick(g, 0, 2);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
            redirect = 1'b0; instr_ready = 1'b0;
            #1;
            checks++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
                errors++;
                $display("FAIL reset_req got req=%b addr=%h want req=0 addr=00000000", imem_req, imem_addr);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_state got v=%b instr=%h pc=%h pc4=%h want v=0 instr=%h pc=0 pc4=4",
                     instr_valid, instr, instr_pc, instr_pc_plus4, NOP);
        end
        mem_busy = 1'b0; gwait = pick(gnt_cfg, 0, 2); exp_pc = '0;
        p_stall = 1'b0; p_pend = 1'b0; p_redir = 1'b0;
    endtask

    // One clock cycle: drive inputs, run the memory model, check against the PC model.
    task automatic step(input bit rdy, input bit rd, input logic [31:0] tgt);
        bit xfer, fire;
        @(negedge clk);
        rst = 1'b0;
        instr_ready = rdy; redirect = rd; redirect_target = tgt;
        imem_rvalid = 1'b0; imem_rdata = $urandom;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
        #1;
        imem_gnt = 1'b0;
        if (imem_req === 1'b1) begin
            if (gwait == 0) imem_gnt = 1'b1;
            else gwait--;
        end
        #1;
        checks++;
        if ($isunknown({imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4})) begin
            errors++;
            $display("FAIL x_on_outputs cyc=%0d req=%b v=%b pc=%h", cyc, imem_req, instr_valid, instr_pc);
        end
        if (p_redir) begin
            checks++;
            if (instr_valid !== 1'b0 || instr !== NOP) begin
                errors++;
                $display("FAIL redirect_flush cyc=%0d got v=%b instr=%h want v=0 instr=%h", cyc, instr_valid, instr, NOP);
            end
        end
        if (p_stall) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== p_instr || instr_pc !== p_pc) begin
                errors++;
                $display("FAIL slot_hold cyc=%0d got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h",
                         cyc, instr_valid, instr, instr_pc, p_instr, p_pc);
            end
        end
        if (p_pend && !rd) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                errors++;
                $display("FAIL req_hold cyc=%0d got req=%b addr=%h want req=1 addr=%h", cyc, imem_req, imem_addr, p_addr);
            end
        end
        if ((instr_valid === 1'b1 && !rdy) || rd) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL req_blocked cyc=%0d got req=%b want 0", cyc, imem_req);
            end
        end
        xfer = (instr_valid === 1'b1) && rdy;
        fire = (imem_req === 1'b1) && imem_gnt;
        if (xfer) begin
            checks++;
            if (instr_pc !== exp_pc || instr !== memf(exp_pc) || instr_pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL xfer cyc=%0d got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                         cyc, instr_pc, instr, instr_pc_plus4, exp_pc, memf(exp_pc), exp_pc + 32'd4);
            end
            xfer_log.push_back(instr_pc);
            xfer_cyc.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
        end
        if (fire) begin
            checks++;
            if (imem_addr !== exp_pc || mem_busy) begin
                errors++;
                $display("FAIL fetch_addr cyc=%0d got addr=%h busy=%b want addr=%h busy=0", cyc, imem_addr, mem_busy, exp_pc);
            end
            gnt_log.push_back(imem_addr);
        end
        if (rd) exp_pc = {tgt[31:2], 2'b00};
        if (imem_rvalid) mem_busy = 1'b0;
        if (fire) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = pick(lat_cfg, 1, 3);
            gwait    = pick(gnt_cfg, 0, 2);
        end
        p_stall = (instr_valid === 1'b1) && !rdy && !rd;
        p_instr = instr; p_pc = instr_pc;
        p_pend  = (imem_req === 1'b1) && !imem_gnt;
        p_addr  = imem_addr; p_redir = rd;
        last_req = (imem_req === 1'b1); last_gnt = imem_gnt;
        last_rvalid = imem_rvalid; last_addr = imem_addr;
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        set_mem(0, 1);
        do_reset(3);
    endtask

    task automatic test_run();
        int c0, n0, g0;
        c0 = cyc; n0 = xfer_log.size(); g0 = gnt_log.size();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        checks++;
        if (gnt_log.size() < g0 + 3 || gnt_log[g0] !== 32'h0 || gnt_log[g0+1] !== 32'h4 || gnt_log[g0+2] !== 32'h8) begin
            errors++;
            $display("FAIL run_fetch_seq got n=%0d want fetches 0,4,8", gnt_log.size() - g0);
        end
        checks++;
        if (xfer_log.size() < n0 + 3 || xfer_log[n0] !== 32'h0 || xfer_log[n0+1] !== 32'h4 ||
            xfer_log[n0+2] !== 32'h8 || xfer_cyc[n0] != c0 + 2 || xfer_cyc[n0+1] != c0 + 4) begin
            errors++;
            $display("FAIL run_xfer got n=%0d want pcs 0,4,8 at cycles +2,+4,+6", xfer_log.size() - n0);
        end
    endtask

    task automatic test_stall();
        int g0;
        set_mem(0, 1);
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            errors++;
            $display("FAIL stall_setup got v=%b pc=%h want v=1 pc=00000004", instr_valid, instr_pc);
        end
        g0 = gnt_log.size();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        checks++;
        if (gnt_log.size() != g0) begin
            errors++;
            $display("FAIL stall_no_fetch got %0d grants want 0", gnt_log.size() - g0);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        checks++;
        if (gnt_log.size() <= g0 || gnt_log[g0] !== 32'h8) begin
            errors++;
            $display("FAIL stall_next_fetch got n=%0d want first fetch 00000008", gnt_log.size() - g0);
        end
    endtask

    task automatic test_redirect_wait();
        int  n0, g0;
        bit  found, bad;
        set_mem(0, 3);
        n0 = xfer_log.size();
        step(1'b1, 1'b1, 32'h10);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, '0);
            found = last_gnt && last_addr == 32'h10;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rdw_gnt got no grant for 00000010 want one within 20 cycles");
        end
        step(1'b1, 1'b1, 32'h103);
        g0 = gnt_log.size();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
        bad = 1'b0;
        for (int i = n0; i < xfer_log.size(); i++) if (xfer_log[i] == 32'h10) bad = 1'b1;
        checks++;
        if (bad || gnt_log.size() <= g0 || gnt_log[g0] !== 32'h100) begin
            errors++;
            $display("FAIL rdw_target got stale_valid=%b next_fetch_n=%0d want stale_valid=0 next fetch 00000100",
                     bad, gnt_log.size() - g0);
        end
        checks++;
        if (xfer_log.size() <= n0 || xfer_log[xfer_log.size()-1] == 32'h10 || !(xfer_log[n0] == 32'h100)) begin
            errors++;
            $display("FAIL rdw_valid got n=%0d want first valid pc 00000100", xfer_log.size() - n0);
        end
    endtask

    task automatic test_redirect_rvalid();
        int n0, g0;
        bit found;
        set_mem(0, 1);
        step(1'b1, 1'b1, 32'h20);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, '0);
            found = last_gnt && last_addr == 32'h20;
        end
        n0 = xfer_log.size(); g0 = gnt_log.size();
        step(1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b0, '0);
        checks++;
        if (!found || !last_req || last_addr !== 32'h40 || gnt_log.size() != g0 + 1) begin
            errors++;
            $display("FAIL rdr_next_req got req=%b addr=%h want req=1 addr=00000040", last_req, last_addr);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
        checks++;
        if (xfer_log.size() <= n0 || xfer_log[n0] !== 32'h40) begin
            errors++;
            $display("FAIL rdr_valid got n=%0d want first valid pc 00000040", xfer_log.size() - n0);
        end
    endtask

    task automatic test_wrap();
        int n0, g0, nreq;
        bit found;
        set_mem(2, 1);
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        nreq = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b1, 1'b0, '0);
            if (last_req && last_addr == 32'hFFFF_FFFC) nreq++;
            found = last_gnt;
        end
        checks++;
        if (!found || nreq != 3 || last_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_gnt_wait got found=%b req_cycles=%0d addr=%h want found=1 req_cycles=3 addr=fffffffc",
                     found, nreq, last_addr);
        end
        n0 = xfer_log.size(); g0 = gnt_log.size();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
        checks++;
        if (xfer_log.size() < n0 + 2 || xfer_log[n0] !== 32'hFFFF_FFFC || xfer_log[n0+1] !== 32'h0 ||
            gnt_log.size() <= g0 || gnt_log[g0] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_seq got n=%0d want valid pcs fffffffc,00000000 and next fetch 00000000",
                     xfer_log.size() - n0);
        end
    endtask

    task automatic test_random();
        int          n0;
        bit          rdy, rd;
        logic [31:0] tgt;
        set_mem(-1, -1);
        n0 = xfer_log.size();
        for (int i = 0; i < 600; i++) begin
            rdy = $urandom_range(9, 0) < 7;
            rd  = $urandom_range(15, 0) == 0;
            tgt = $urandom;
            if ($urandom_range(3, 0) == 0) tgt[31:4] = '1;
            step(rdy, rd, tgt);
        end
        checks++;
        if (xfer_log.size() - n0 < 30) begin
            errors++;
            $display("FAIL random_progress got %0d transfers want at least 30", xfer_log.size() - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0, g0;
        bit found;
        set_mem(0, 1);
        step(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) step(1'b0, 1'b0, '0);
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup got v=%b want 1", instr_valid);
        end
        do_reset(1);
        set_mem(0, 3);
        step(1'b1, 1'b1, 32'h300);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b0, '0);
            found = last_gnt;
        end
        do_reset(1);
        n0 = xfer_log.size(); g0 = gnt_log.size();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        checks++;
        if (!found || gnt_log.size() <= g0 || gnt_log[g0] !== 32'h0 || xfer_log.size() <= n0 || xfer_log[n0] !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_restart got fetches=%0d xfers=%0d want first fetch and valid at 00000000",
                     gnt_log.size() - g0, xfer_log.size() - n0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the control unit and decode.
- Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface, with at most one request outstanding.
- Presents each fetched instruction and its PC to decode through a valid/ready handshake.
- Accepts a redirect (pc_src plus branch/jump target) from execute, which flushes wrong-path instructions.

Parameters:
- XLEN, 32, data and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value of instr while invalid or after reset (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; cannot be backpressured.
- imem_rdata  in  XLEN  response instruction word.
- redirect  in  1  taken branch/jump (pc_src).
- redirect_target  in  XLEN  new PC; bits [1:0] ignored.
- instr_valid  out  1  instr/instr_pc valid toward decode.
- instr_ready  in  1  decode accepts this cycle.
- instr  out  XLEN  instruction word.
- instr_pc  out  XLEN  address of instr.
- instr_pc_plus4  out  XLEN  instr_pc + 4, modulo 2^XLEN.

Behaviour:
- State machine: REQ, WAIT. Registers: fetch_pc, discard flag, output slot (instr, instr_pc, instr_valid).
- Reset (rst=1): state=REQ, fetch_pc=RESET_PC, discard=0, instr_valid=0, instr=NOP_INSTR, instr_pc=0. During reset, imem_req=0 and imem_addr=RESET_PC. Memory shares rst, so no response arrives after reset. Reset mid-transaction abandons it.
- REQ:
  - imem_req=1 when the slot is free (instr_valid=0, or instr_valid&instr_ready this cycle) and redirect=0.
  - imem_addr=fetch_pc.
  - req and addr stay stable until gnt.
  - gnt takes the FSM to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with discard=0 and redirect=0: load slot (instr=rdata, instr_pc=fetch_pc, instr_valid=1), fetch_pc+=4 (wraps at 2^XLEN), go to REQ.
  - On imem_rvalid with discard=1: drop the data, clear discard, go to REQ.
- Handshake:
  - Slot output is registered; the transfer occurs on instr_valid&instr_ready.
  - Slot holds its values stable while instr_valid=1 and instr_ready=0.
  - instr_valid clears on transfer unless reloaded in the same cycle.
- Redirect (highest priority after rst):
  - fetch_pc <= {redirect_target[XLEN-1:2],2'b00}; instr_valid <= 0; instr <= NOP_INSTR.
  - In REQ: imem_req is forced 0 that cycle, so nothing is granted for the old address. The next cycle requests the target.
  - In WAIT without rvalid: set discard=1. The pending response is dropped on arrival.
  - In WAIT with rvalid the same cycle: response dropped, discard stays 0, go to REQ.
  - A redirect coincident with instr_valid&instr_ready counts as transferred; the slot is simply cleared.
  - Back-to-back redirects: the last one wins. discard stays 1 while a response is outstanding.
- Latency and throughput (zero-wait memory, gnt same cycle as req, rvalid next cycle):
  - First instr_valid 2 cycles after rst falls.
  - Redirect-to-target-valid: 2 cycles from REQ.
  - Sustained throughput is 1 instruction per 2 cycles; one outstanding request is a deliberate simplification.
- instr_pc_plus4 is combinational from instr_pc.
- No X on outputs after the first reset cycle.

Test Plan:
- Reset then run: rst 1 for 3 cycles with RESET_PC=0 and zero-wait memory returning addr→{addr,0x13}. Required: imem_req=0 during rst. Fetches go to 0x0, 0x4, 0x8. instr_valid pulses carry instr_pc 0x0/0x4/0x8 and instr_pc_plus4 0x4/0x8/0xC.
- Decode stall: hold instr_ready=0 for 5 cycles while instr_pc=0x4 is valid. Required: instr and instr_pc stable, and no new imem_req until ready=1. The next fetch is 0x8.
- Redirect in WAIT:
  - Stimulus: gnt for 0x10; memory delays rvalid 3 cycles; redirect=1 with target 0x103 in the cycle after gnt.
  - Required: the 0x10 response is discarded and never becomes valid. The next request is addr 0x100. Valid then carries instr_pc=0x100.
- Redirect coincident with rvalid: rvalid for 0x20 in the same cycle as redirect to 0x40. Required: no valid for 0x20; the next req is addr 0x40 in the following cycle.
- Wrap and gnt wait:
  - Stimulus: redirect to 0xFFFF_FFFC; memory delays gnt 2 cycles.
  - Required: imem_addr held at 0xFFFF_FFFC until gnt. Then instr_pc=0xFFFF_FFFC and instr_pc_plus4=0x0. The next fetch is 0x0.
- Reset mid-operation: assert rst while in WAIT with instr_valid=1. Required: the next cycle has instr_valid=0, instr=0x13, and fetch restarts at RESET_PC.
